part_nxm_dpram: RTL and testbench

PART_NXM_DPRAM -- requirements
Module: part_nxm_dpram

---
 rtl/part_ram_pkg.sv | 20 ++
 rtl/part_dpram_clear_seq.sv | 62 ++++++
 rtl/part_nxm_dpram.sv | 136 +++++++++++++
 tb/tb_part_nxm_dpram.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/part_ram_pkg.sv
// part_ram_pkg -- shared definitions for the partitioned RAM family.
//   clr_state_t : state encoding of the power-up clear sequencer
//   clog2()     : ceiling log2, used to size counters and array indices
package part_ram_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_READY = 2'd2
  } clr_state_t;

  // Smallest r such that 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/part_dpram_clear_seq.sv
// part_dpram_clear_seq -- zero-fill sweep for part_nxm_dpram.
// Built only when DPRAM_CLEAR_EN is defined.
//   clk_a    : clock, rising edge
//   reset    : synchronous active-high; (re)starts the sweep at address 0
//   busy     : high while the sweep owns the memory
//   clr_we   : write strobe for the zero word
//   clr_addr : address being cleared this cycle
// Reset parks the FSM in CLEAR with the counter at 0. After release, one
// word is cleared per cycle for DEPTH cycles, then the FSM rests in READY.
module part_dpram_clear_seq
  import part_ram_pkg::*;
#(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic              clk_a,
  input  logic              reset,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam int CNT_W = clog2(DEPTH);

  clr_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk_a) begin
    if (reset) begin
      state <= CLR_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    clr_we    = 1'b0;
    case (state)
      CLR_IDLE: begin
        // Only reachable before the first reset; nothing to do.
      end
      CLR_CLEAR: begin
        busy   = 1'b1;
        // No writes while reset is held: the sweep proper begins on release.
        clr_we = !reset;
        if (cnt == CNT_W'(DEPTH - 1)) state_nxt = CLR_READY;
        else                           cnt_nxt   = cnt + 1'b1;
      end
      CLR_READY: begin
      end
      default: state_nxt = CLR_IDLE;
    endcase
  end

  assign clr_addr = ADDR_W'(cnt);

endmodule

// File: rtl/part_nxm_dpram.sv
// part_nxm_dpram -- true dual-port RAM, single clock, old-data read-during-write.
//   clk_a                 : clock for both ports, rising edge
//   reset                 : synchronous active-high; clears outputs, not memory
//   address_a/address_b   : word address per port
//   data_a/data_b         : write data per port
//   wren_a/wren_b         : write enable per port
//   rden_a/rden_b         : read enable per port; q_x holds while low
//   q_a/q_b               : read data, 1 cycle latency (2 with OUT_REG=1)
//   busy                  : high while the clear sweep runs; ports ignored
//   collision             : one-cycle pulse after a same-address dual write
// Build option: define DPRAM_CLEAR_EN to zero-fill the array after every
// reset (part_dpram_clear_seq). Without it the array powers up undefined
// and busy is tied low.
// Out-of-range addresses (>= DEPTH) never write and always read zero.
// On a same-address dual write port A wins.
module part_nxm_dpram
  import part_ram_pkg::*;
#(
  parameter int WIDTH   = 5,
  parameter int DEPTH   = 2048,
  parameter int ADDR_W  = 11,
  parameter int OUT_REG = 0
) (
  input  logic              clk_a,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [WIDTH-1:0]  data_a,
  input  logic [WIDTH-1:0]  data_b,
  input  logic              wren_a,
  input  logic              wren_b,
  input  logic              rden_a,
  input  logic              rden_b,
  output logic [WIDTH-1:0]  q_a,
  output logic [WIDTH-1:0]  q_b,
  output logic              busy,
  output logic              collision
);

  localparam int IDX_W = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic              clr_busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

`ifdef DPRAM_CLEAR_EN
  part_dpram_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear (
    .clk_a    (clk_a),
    .reset    (reset),
    .busy     (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );
`else
  assign clr_busy = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  assign busy = clr_busy;

  logic             port_ok;
  logic             in_a, in_b, same_addr;
  logic             we_a, we_b, re_a, re_b;
  logic [IDX_W-1:0] idx_a, idx_b, clr_idx;

  // Range check done one bit wider so DEPTH == 2**ADDR_W still works.
  assign in_a      = {1'b0, address_a} < (ADDR_W + 1)'(DEPTH);
  assign in_b      = {1'b0, address_b} < (ADDR_W + 1)'(DEPTH);
  assign same_addr = (address_a == address_b);
  assign port_ok   = !busy && !reset;

  // Truncation is safe: every use is qualified by the range check.
  assign idx_a   = address_a[IDX_W-1:0];
  assign idx_b   = address_b[IDX_W-1:0];
  assign clr_idx = clr_addr[IDX_W-1:0];

  assign we_a = wren_a && port_ok && in_a;
  assign we_b = wren_b && port_ok && in_b && !(we_a && same_addr);
  assign re_a = rden_a && port_ok;
  assign re_b = rden_b && port_ok;

  always_ff @(posedge clk_a) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else begin
      if (we_a) mem[idx_a] <= data_a;
      if (we_b) mem[idx_b] <= data_b;
    end
  end

  // Stage p0: array read (sees pre-write contents) and collision detect.
  logic [WIDTH-1:0] q_a_p0, q_b_p0;
  logic             coll_p0;

  always_ff @(posedge clk_a) begin
    if (reset) begin
      q_a_p0  <= '0;
      q_b_p0  <= '0;
      coll_p0 <= 1'b0;
    end else begin
      if (re_a) q_a_p0 <= in_a ? mem[idx_a] : '0;
      if (re_b) q_b_p0 <= in_b ? mem[idx_b] : '0;
      coll_p0 <= wren_a && wren_b && port_ok && in_a && in_b && same_addr;
    end
  end

  assign collision = coll_p0;

  // Stage p1: optional output register on both read ports.
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] q_a_p1, q_b_p1;
      always_ff @(posedge clk_a) begin
        if (reset) begin
          q_a_p1 <= '0;
          q_b_p1 <= '0;
        end else begin
          q_a_p1 <= q_a_p0;
          q_b_p1 <= q_b_p0;
        end
      end
      assign q_a = q_a_p1;
      assign q_b = q_b_p1;
    end else begin : g_no_out_reg
      assign q_a = q_a_p0;
      assign q_b = q_b_p0;
    end
  endgenerate

endmodule

// File: tb/tb_part_nxm_dpram.sv
// tb_part_nxm_dpram -- randomized bench for part_nxm_dpram against a
// behavioural memory model. Three instances share one stimulus stream:
//   0: DEPTH=2048 OUT_REG=0, 1: DEPTH=1000 OUT_REG=1, 2: DEPTH=16 OUT_REG=0
// Sweep scenarios are included when DPRAM_CLEAR_EN is defined.
module tb_part_nxm_dpram;

  logic        clk_a = 1'b0;
  logic        reset;
  logic [10:0] address_a, address_b;
  logic [4:0]  data_a, data_b;
  logic        wren_a, wren_b, rden_a, rden_b;

  logic [4:0]  qa [3];
  logic [4:0]  qb [3];
  logic        busy [3];
  logic        coll [3];

  always #5 clk_a = ~clk_a;

  part_nxm_dpram #(.WIDTH(5), .DEPTH(2048), .ADDR_W(11), .OUT_REG(0)) dut0 (
    .clk_a(clk_a), .reset(reset), .address_a(address_a), .address_b(address_b),
    .data_a(data_a), .data_b(data_b), .wren_a(wren_a), .wren_b(wren_b),
    .rden_a(rden_a), .rden_b(rden_b), .q_a(qa[0]), .q_b(qb[0]),
    .busy(busy[0]), .collision(coll[0]));

  part_nxm_dpram #(.WIDTH(5), .DEPTH(1000), .ADDR_W(11), .OUT_REG(1)) dut1 (
    .clk_a(clk_a), .reset(reset), .address_a(address_a), .address_b(address_b),
    .data_a(data_a), .data_b(data_b), .wren_a(wren_a), .wren_b(wren_b),
    .rden_a(rden_a), .rden_b(rden_b), .q_a(qa[1]), .q_b(qb[1]),
    .busy(busy[1]), .collision(coll[1]));

  part_nxm_dpram #(.WIDTH(5), .DEPTH(16), .ADDR_W(11), .OUT_REG(0)) dut2 (
    .clk_a(clk_a), .reset(reset), .address_a(address_a), .address_b(address_b),
    .data_a(data_a), .data_b(data_b), .wren_a(wren_a), .wren_b(wren_b),
    .rden_a(rden_a), .rden_b(rden_b), .q_a(qa[2]), .q_b(qb[2]),
    .busy(busy[2]), .collision(coll[2]));

  int n_vec = 0;
  int n_err = 0;

  // Reference model state per instance.
  int         dep [3] = '{2048, 1000, 16};
  int         lat [3] = '{1, 2, 1};
  logic [4:0] m    [3][2048];
  logic [4:0] ea1  [3];
  logic [4:0] ea2  [3];
  logic [4:0] eb1  [3];
  logic [4:0] eb2  [3];
  logic       ecoll[3];
  logic       sweeping [3];
  int         sidx [3];
  int         pool [22];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after.
  task automatic cyc(input logic r, input logic wa, input logic [10:0] aa, input logic [4:0] da,
                     input logic wb, input logic [10:0] ab, input logic [4:0] db,
                     input logic ra, input logic rb);
    reset = r; wren_a = wa; address_a = aa; data_a = da;
    wren_b = wb; address_b = ab; data_b = db; rden_a = ra; rden_b = rb;
    @(posedge clk_a);
    for (int d = 0; d < 3; d++) begin
      if (r) begin
        ea1[d] = '0; ea2[d] = '0; eb1[d] = '0; eb2[d] = '0; ecoll[d] = 1'b0;
`ifdef DPRAM_CLEAR_EN
        sweeping[d] = 1'b1; sidx[d] = 0;
`endif
      end else begin
        logic ign;
        ign = sweeping[d];
        ea2[d] = ea1[d];
        eb2[d] = eb1[d];
        if (ra && !ign) ea1[d] = (int'(aa) < dep[d]) ? m[d][aa] : 5'd0;
        if (rb && !ign) eb1[d] = (int'(ab) < dep[d]) ? m[d][ab] : 5'd0;
        ecoll[d] = !ign && wa && wb && (aa == ab) && (int'(aa) < dep[d]);
        if (!ign) begin
          if (wb && int'(ab) < dep[d]) m[d][ab] = db;
          if (wa && int'(aa) < dep[d]) m[d][aa] = da;   // A overrides B
        end
        if (sweeping[d]) begin
          m[d][sidx[d]] = 5'd0;
          sidx[d]++;
          if (sidx[d] == dep[d]) sweeping[d] = 1'b0;
        end
      end
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("q_a[%0d]", d), 32'(qa[d]), 32'((lat[d] == 1) ? ea1[d] : ea2[d]));
      chk($sformatf("q_b[%0d]", d), 32'(qb[d]), 32'((lat[d] == 1) ? eb1[d] : eb2[d]));
      chk($sformatf("collision[%0d]", d), 32'(coll[d]), 32'(ecoll[d]));
      chk($sformatf("busy[%0d]", d), 32'(busy[d]), 32'(sweeping[d]));
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 11'd0, 5'd0, 1'b0, 11'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [10:0] ra_a, ra_b;
    for (int d = 0; d < 3; d++) begin
      sweeping[d] = 1'b0; sidx[d] = 0;
      ea1[d] = '0; ea2[d] = '0; eb1[d] = '0; eb2[d] = '0; ecoll[d] = 1'b0;
    end
    for (int i = 0; i < 16; i++) pool[i] = i;
    pool[16] = 998;  pool[17] = 999;  pool[18] = 1000;
    pool[19] = 1001; pool[20] = 2046; pool[21] = 2047;

    // Reset: outputs zero, collision low.
    cyc(1'b1, 1'b0, 11'd0, 5'd0, 1'b0, 11'd0, 5'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 11'd3, 5'd9, 1'b0, 11'd0, 5'd0, 1'b1, 1'b1);

`ifdef DPRAM_CLEAR_EN
    // Sweep after release, with write attempts that must be dropped.
    n = 0;
    while (busy[2] && n < 40) begin
      n++;
      cyc(1'b0, 1'b1, 11'($urandom_range(0, 15)), 5'($urandom), 1'b1,
          11'($urandom_range(0, 15)), 5'($urandom), 1'b1, 1'b0);
    end
    chk("sweep16_busy_len", n, 16);
    n = 0;
    while (busy[0] && n < 3000) begin n++; idle(); end
    chk("sweep2048_done", 32'(busy[0]), 0);
    for (int a = 0; a < 16; a++) begin
      cyc(1'b0, 1'b0, 11'(a), 5'd0, 1'b0, 11'(a), 5'd0, 1'b1, 1'b1);
      chk("cleared_word", 32'(qa[2]), 0);
    end
    // Reset while the sweep sits at address 7: full-length restart.
    cyc(1'b1, 1'b0, 11'd0, 5'd0, 1'b0, 11'd0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) idle();
    chk("sweep_at_7", sidx[2], 7);
    cyc(1'b1, 1'b0, 11'd0, 5'd0, 1'b0, 11'd0, 5'd0, 1'b0, 1'b0);
    n = 0;
    while (busy[2] && n < 40) begin n++; idle(); end
    chk("restart_busy_len", n, 16);
    n = 0;
    while (busy[0] && n < 3000) begin n++; idle(); end
    chk("restart2048_done", 32'(busy[0]), 0);
`endif

    // Give every address in the pool a known value.
    for (int i = 0; i < 22; i++)
      cyc(1'b0, 1'b1, 11'(pool[i]), 5'($urandom), 1'b0, 11'd0, 5'd0, 1'b0, 1'b0);

    // Write A then read B one cycle later.
    cyc(1'b0, 1'b1, 11'o17, 5'o25, 1'b0, 11'd0, 5'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 11'd0, 5'd0, 1'b0, 11'o17, 5'd0, 1'b0, 1'b1);
    chk("wr_a_rd_b", 32'(qb[0]), 32'o25);

    // Same-address dual write: A wins, one-cycle collision pulse.
    cyc(1'b0, 1'b1, 11'd5, 5'd3, 1'b1, 11'd5, 5'd7, 1'b0, 1'b0);
    chk("coll_pulse", 32'(coll[0]), 1);
    cyc(1'b0, 1'b0, 11'd5, 5'd0, 1'b0, 11'd0, 5'd0, 1'b1, 1'b0);
    chk("coll_drop", 32'(coll[0]), 0);
    chk("coll_a_wins", 32'(qa[0]), 3);

    // Mixed-port read-during-write returns old data.
    cyc(1'b0, 1'b1, 11'd9, 5'd1, 1'b0, 11'd0, 5'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 11'd9, 5'd0, 1'b1, 11'd9, 5'd2, 1'b1, 1'b0);
    chk("rdw_old", 32'(qa[0]), 1);
    cyc(1'b0, 1'b0, 11'd9, 5'd0, 1'b0, 11'd0, 5'd0, 1'b1, 1'b0);
    chk("rdw_new", 32'(qa[0]), 2);

    // Registered output, boundary addresses on the DEPTH=1000 instance.
    cyc(1'b0, 1'b1, 11'd999, 5'o31, 1'b0, 11'd0, 5'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 11'd999, 5'd0, 1'b0, 11'd0, 5'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 11'd1000, 5'd0, 1'b0, 11'd0, 5'd0, 1'b1, 1'b0);
    chk("oreg_999", 32'(qa[1]), 32'o31);
    idle();
    chk("oreg_1000", 32'(qa[1]), 0);

    // Randomized traffic over the pool addresses.
    for (int i = 0; i < 500; i++) begin
      ra_a = 11'(pool[$urandom_range(0, 21)]);
      ra_b = ($urandom_range(0, 3) == 0) ? ra_a : 11'(pool[$urandom_range(0, 21)]);
      cyc(1'b0, 1'($urandom), ra_a, 5'($urandom), 1'($urandom), ra_b, 5'($urandom),
          1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
